// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
// The state enum, the fetch NOP and the default memory depth live here.
package imem_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        ERROR = 2'd3
    } state_t;

    // RISC-V "addi x0, x0, 0"
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int DEFAULT_DEPTH = 64;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Loader and core-side signal bundle of the boot controller.
// Valid/ready: a loader word transfers on a rising edge where ld_valid && ld_ready; ld_data/ld_last are held while ld_valid is high and ld_ready is low.
interface imem_boot_ctrl_if #(
    parameter int s  = 32,
    parameter int AW = 6
);

    logic          ld_valid;
    logic [s-1:0]  ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          reload;
    logic [s-1:0]  core_pc;
    logic [s-1:0]  core_instr;
    logic          core_stall;
    logic          boot_done;
    logic [AW:0]   load_count;
    logic          err_overflow;
    logic          err_fetch;

    modport master (
        output ld_valid, ld_data, ld_last, reload, core_pc,
        input  ld_ready, core_instr, core_stall, boot_done,
               load_count, err_overflow, err_fetch
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, core_pc,
        output ld_ready, core_instr, core_stall, boot_done,
               load_count, err_overflow, err_fetch
    );

endinterface

// File: rtl/imem_load_counter.sv
// Write pointer / word counter for image loading. The low bits address memory,
// the full value is the loaded word count; tc marks the last in-range word.
module imem_load_counter #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     en,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tc
);

    localparam int CW = $clog2(DEPTH) + 1;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // High while the next accepted word would be the DEPTH-th one.
    assign tc = (count == CW'(DEPTH - 1));

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller: streams a loader image into an external instruction memory,
// then serves zero-latency fetches to the core until a reload is requested.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int s     = 32,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [s-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload,
    input  logic [s-1:0]  core_pc,
    output logic [s-1:0]  core_instr,
    output logic          core_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [s-1:0]  mem_wdata,
    input  logic [s-1:0]  mem_rdata,
    output logic          boot_done,
    output logic [AW:0]   load_count,
    output logic          err_overflow,
    output logic          err_fetch
);

    localparam logic [s:0] PC_LIMIT = (s + 1)'(DEPTH * 4);

    state_t        state;
    state_t        state_nxt;
    logic          handshake;
    logic          cnt_clear;
    logic          cnt_tc;
    logic [AW:0]   cnt;
    logic          fetch_bad;

    // Gating with reset keeps memory untouched during the reset cycle.
    assign ld_ready  = (state == LOAD) && !reset;
    assign handshake = ld_valid && ld_ready;

    // FLUSH clears the counter so LOAD is entered at address 0.
    assign cnt_clear = reset || (state == FLUSH) || ((state == ERROR) && reload);

    imem_load_counter #(
        .DEPTH (DEPTH)
    ) u_load_counter (
        .clk   (clk),
        .clear (cnt_clear),
        .en    (handshake),
        .count (cnt),
        .tc    (cnt_tc)
    );

    assign load_count = cnt;
    assign fetch_bad  = (core_pc[1:0] != 2'b00) || ({1'b0, core_pc} >= PC_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_we       = 1'b0;
        mem_addr     = core_pc[AW+1:2];
        mem_wdata    = '0;
        core_instr   = s'(NOP);
        core_stall   = 1'b1;
        boot_done    = 1'b0;
        err_fetch    = 1'b0;
        err_overflow = 1'b0;

        case (state)
            LOAD: begin
                mem_we    = handshake;
                mem_addr  = cnt[AW-1:0];
                mem_wdata = ld_data;
                if (handshake) begin
                    if (ld_last) begin
                        state_nxt = RUN;
                    end else if (cnt_tc) begin
                        state_nxt = ERROR;
                    end
                end
            end
            RUN: begin
                core_stall = 1'b0;
                boot_done  = 1'b1;
                err_fetch  = fetch_bad;
                core_instr = fetch_bad ? s'(NOP) : mem_rdata;
                if (reload) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = LOAD;
            end
            ERROR: begin
                err_overflow = 1'b1;
                if (reload) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 The block SHALL have parameter s, default 32: instruction/data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64: instruction memory depth in words; AW = $clog2(DEPTH).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-004 The block SHALL have these ports:
  clk  input  1  clock, all state on rising edge
  reset  input  1  synchronous active-high reset
  ld_valid  input  1  loader word valid
  ld_data  input  s  loader instruction word
  ld_last  input  1  final word of image, qualified by ld_valid
  ld_ready  output  1  controller accepts loader word
  reload  input  1  request new image load
  core_pc  input  s  core fetch byte address
  core_instr  output  s  instruction to core
  core_stall  output  1  core holds PC
  mem_we  output  1  memory write enable
  mem_addr  output  AW  memory word address
  mem_wdata  output  s  memory write data
  mem_rdata  input  s  memory asynchronous read data
  boot_done  output  1  image loaded, core running
  load_count  output  AW+1  words written in current load
  err_overflow  output  1  image exceeded DEPTH
  err_fetch  output  1  misaligned or out-of-range fetch

Function
REQ-005 The FSM SHALL have states LOAD, RUN, FLUSH and ERROR.
REQ-006 A handshake SHALL be ld_valid && ld_ready; ld_ready = 1 only in LOAD.
REQ-007 In LOAD, mem_we = handshake, mem_addr = wr_ptr, mem_wdata = ld_data, all combinational; the write commits at that rising edge.
REQ-008 Each handshake SHALL increment wr_ptr and load_count by 1 at the clock edge.
REQ-009 In LOAD, a handshake with ld_last = 1 SHALL move the FSM to RUN, including on the DEPTH-th word.
REQ-010 In LOAD, the DEPTH-th handshake with ld_last = 0 SHALL move the FSM to ERROR.
REQ-011 In RUN: mem_we = 0, mem_addr = core_pc[AW+1:2], core_instr = mem_rdata (zero-cycle latency), core_stall = 0, boot_done = 1.
REQ-012 In RUN, err_fetch SHALL be high combinationally when core_pc[1:0] != 0 or core_pc >= DEPTH*4, and core_instr SHALL then be NOP (32'h00000013).
REQ-013 In LOAD, FLUSH and ERROR: core_instr = NOP, core_stall = 1, boot_done = 0, err_fetch = 0.
REQ-014 reload = 1 in RUN SHALL move the FSM to FLUSH for exactly one cycle, then to LOAD with wr_ptr = 0 and load_count = 0.
REQ-015 reload = 1 in ERROR SHALL move the FSM directly to LOAD, clear err_overflow and zero the counters.
REQ-016 reload SHALL be ignored in LOAD and FLUSH.
REQ-017 In ERROR: err_overflow = 1, ld_ready = 0, mem_we = 0.
REQ-018 In all non-LOAD states, mem_addr SHALL equal core_pc[AW+1:2] and mem_wdata SHALL be 0.

Reset
REQ-019 Reset SHALL force state = LOAD, wr_ptr = 0, load_count = 0, boot_done = 0 and err_overflow = 0, taking priority over every other input.
REQ-020 A reset during a load SHALL restart writing at address 0 and SHALL NOT clear memory contents.
REQ-021 During the reset cycle, mem_we SHALL be 0.

Structure
REQ-022 Package imem_pkg SHALL hold the state enum, the NOP constant and the default DEPTH.
REQ-023 The wr_ptr/load_count counter SHALL be the single sub-module imem_load_counter (sync clear, enable, terminal-count flag).
REQ-024 The memory array SHALL be external to this block.

Verification
REQ-025 Load and run: after reset, load 0x002081B3, 0x403202B3, 0x00308383 with ld_last on the third -> mem_we at addresses 0, 1, 2; next cycle boot_done = 1 and load_count = 3; core_pc = 8 -> core_instr = 0x00308383.
REQ-026 Loader gaps: ld_valid toggling with core_pc = 0 in LOAD -> core_instr = 0x00000013, core_stall = 1, no write on idle cycles.
REQ-027 Overflow: DEPTH = 64, 64 words with ld_last = 0 -> ERROR, err_overflow = 1, ld_ready = 0; then reload = 1 -> LOAD with load_count = 0 and err_overflow = 0.
REQ-028 Bad fetch: in RUN, core_pc = 0x2 -> NOP with err_fetch = 1; core_pc = 0x100 -> NOP with err_fetch = 1.
REQ-029 Reset mid-load after 2 words -> the next handshake writes address 0 and load_count = 1.
REQ-030 reload in RUN with ld_valid = 1 -> no write in FLUSH, one NOP cycle, then the first LOAD handshake writes address 0.
